// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with hold limit and turnaround gap
module bus_arbiter #(
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  output logic grant1,
  output logic grant2,
  output logic master_select,
  output logic bus_busy,
  output logic preempt
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, TURN} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [TW-1:0] turn_cnt_q, turn_cnt_d;
  logic          last_owner_q, last_owner_d;  // 1 = master1 owned last
  logic          grant1_q, grant1_d;
  logic          grant2_q, grant2_d;
  logic          select_q, select_d;
  logic          busy_q, busy_d;
  logic          preempt_q, preempt_d;
  logic          own_req, other_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      turn_cnt_q   <= '0;
      last_owner_q <= 1'b0;
      grant1_q     <= 1'b0;
      grant2_q     <= 1'b0;
      select_q     <= 1'b1;
      busy_q       <= 1'b0;
      preempt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
      last_owner_q <= last_owner_d;
      grant1_q     <= grant1_d;
      grant2_q     <= grant2_d;
      select_q     <= select_d;
      busy_q       <= busy_d;
      preempt_q    <= preempt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    turn_cnt_d   = turn_cnt_q;
    last_owner_d = last_owner_q;
    select_d     = select_q;
    preempt_d    = 1'b0;
    own_req      = (state_q == GRANT1) ? req1 : req2;
    other_req    = (state_q == GRANT1) ? req2 : req1;

    case (state_q)
      IDLE: begin
        if (req1 && (!req2 || !last_owner_q)) begin
          state_d      = GRANT1;
          last_owner_d = 1'b1;
          hold_cnt_d   = '0;
          select_d     = 1'b1;
        end else if (req2) begin
          state_d      = GRANT2;
          last_owner_d = 1'b0;
          hold_cnt_d   = '0;
          select_d     = 1'b0;
        end
      end
      GRANT1, GRANT2: begin
        // A release on the expiry edge wins over the preemption
        if (!own_req) begin
          state_d    = TURN;
          turn_cnt_d = '0;
        end else if (other_req && hold_cnt_q == HOLD_LAST) begin
          state_d    = TURN;
          turn_cnt_d = '0;
          preempt_d  = 1'b1;
        end else if (other_req) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) state_d = IDLE;
        else                         turn_cnt_d = turn_cnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase

    grant1_d = (state_d == GRANT1);
    grant2_d = (state_d == GRANT2);
    busy_d   = (state_d != IDLE);
  end

  assign grant1        = grant1_q;
  assign grant2        = grant2_q;
  assign master_select = select_q;
  assign bus_busy      = busy_q;
  assign preempt       = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed checks of bus_arbiter against a tenure-level model
module tb_bus_arbiter;

  localparam int MAX_HOLD   = 16;
  localparam int TURNAROUND = 2;

  logic clk = 1'b0;
  logic rst, req1, req2;
  logic grant1, grant2, master_select, bus_busy, preempt;

  int vectors = 0;
  int miscompares = 0;

  // model: who owns the bus, how many turnaround cycles remain, contended-cycle count
  int m_owner, m_gap, m_contended, m_last;
  bit m_sel, m_pre;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2),
    .grant1(grant1), .grant2(grant2), .master_select(master_select),
    .bus_busy(bus_busy), .preempt(preempt)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r1, input bit r2, input bit rs);
    bit own, oth;
    if (rs) begin
      m_owner = 0; m_gap = 0; m_contended = 0; m_last = 2; m_sel = 1; m_pre = 0;
      return;
    end
    m_pre = 0;
    if (m_owner != 0) begin
      own = (m_owner == 1) ? r1 : r2;
      oth = (m_owner == 1) ? r2 : r1;
      if (!own) begin
        m_owner = 0; m_gap = TURNAROUND;
      end else if (oth) begin
        m_contended++;
        if (m_contended == MAX_HOLD) begin
          m_owner = 0; m_gap = TURNAROUND; m_pre = 1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      if (r1 && r2)  m_owner = (m_last == 1) ? 2 : 1;
      else if (r1)   m_owner = 1;
      else if (r2)   m_owner = 2;
      if (m_owner != 0) begin
        m_last = m_owner; m_sel = (m_owner == 1); m_contended = 0;
      end
    end
  endtask

  task automatic step(input bit r1, input bit r2, input bit rs);
    req1 = r1; req2 = r2; rst = rs;
    @(posedge clk);
    model_edge(r1, r2, rs);
    #1;
    check("grant1", int'(grant1), int'(m_owner == 1));
    check("grant2", int'(grant2), int'(m_owner == 2));
    check("master_select", int'(master_select), int'(m_sel));
    check("bus_busy", int'(bus_busy), int'(m_owner != 0 || m_gap > 0));
    check("preempt", int'(preempt), int'(m_pre));
    @(negedge clk);
  endtask

  initial begin
    int g1_run, pulses;
    bit r1, r2;
    req1 = 0; req2 = 0; rst = 1;
    @(negedge clk);

    // reset, then idle
    step(0, 0, 1); step(0, 0, 1);
    check("reset_select", int'(master_select), 1);
    repeat (10) step(0, 0, 0);

    // single master 2, then release
    repeat (4) step(0, 0, 0);
    repeat (7) step(0, 1, 0);
    repeat (5) step(0, 0, 0);

    // tie from reset release, round robin
    step(0, 0, 1);
    repeat (4) step(1, 1, 0);
    step(0, 1, 0);
    repeat (6) step(1, 1, 0);
    repeat (8) step(1, 0, 0);
    repeat (5) step(0, 0, 0);

    // preemption: req2 rises in the first tenure cycle
    step(0, 0, 1);
    g1_run = 0; pulses = 0;
    for (int i = 0; i < 22; i++) begin
      step(1, (i > 0), 0);
      g1_run += int'(grant1);
      pulses += int'(preempt);
    end
    check("contended_tenure_len", g1_run, MAX_HOLD);
    check("preempt_pulses", pulses, 1);
    repeat (5) step(0, 0, 0);

    // release and expiry on the same edge
    step(0, 0, 1);
    step(1, 0, 0);
    repeat (MAX_HOLD - 1) step(1, 1, 0);
    step(0, 1, 0);
    check("same_edge_preempt", int'(preempt), 0);
    repeat (6) step(0, 1, 0);

    // reset mid-tenure, then tie goes to master1
    step(0, 1, 1);
    check("rst_mid_grant2", int'(grant2), 0);
    check("rst_mid_select", int'(master_select), 1);
    step(1, 1, 0);
    check("post_reset_tie", int'(grant1), 1);
    repeat (4) step(0, 0, 0);

    // random level requests with occasional reset
    r1 = 0; r2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) r1 = ~r1;
      if ($urandom_range(0, 9) == 0) r2 = ~r2;
      step(r1, r2, ($urandom_range(0, 299) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
